// File: rtl/uart_av_master_if.sv
// Signal bundle between uart_av_master and its user / uart_core neighbours.
// Holds the TX/RX streams, the core IRQ and the Avalon-MM register port.
interface uart_av_master_if;
  logic [7:0]  tx_data_i;
  logic        tx_valid_i;
  logic        tx_ready_o;
  logic        tx_drop_o;
  logic [7:0]  rx_data_o;
  logic        rx_valid_o;
  logic        rx_ready_i;
  logic        irq_i;
  logic [3:0]  avm_address_o;
  logic [3:0]  avm_byteenable_o;
  logic        avm_read_o;
  logic        avm_write_o;
  logic [31:0] avm_writedata_o;
  logic [31:0] avm_readdata_i;

  modport master (
    input  tx_data_i, tx_valid_i, rx_ready_i,
    input  irq_i, avm_readdata_i,
    output tx_ready_o, tx_drop_o,
    output rx_data_o, rx_valid_o,
    output avm_address_o, avm_byteenable_o,
    output avm_read_o, avm_write_o,
    output avm_writedata_o
  );

  modport slave (
    output tx_data_i, tx_valid_i, rx_ready_i,
    output irq_i, avm_readdata_i,
    input  tx_ready_o, tx_drop_o,
    input  rx_data_o, rx_valid_o,
    input  avm_address_o, avm_byteenable_o,
    input  avm_read_o, avm_write_o,
    input  avm_writedata_o
  );
endinterface

// File: rtl/uart_av_master.sv
// Avalon-MM master polling uart_core: writes held TX bytes, reads RX on IRQ.
// Ports: clk_i, reset_n_i (sync, active-low), bus (uart_av_master_if.master).
module uart_av_master #(
  parameter int CLK_FREQ       = 100_000_000,
  parameter int BAUD_RATE      = 115_200,
  parameter int READ_LATENCY   = 2,
  parameter int POLL_GAP       = 4,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  uart_av_master_if.master bus
);
  localparam int RX_DELAY = 10 * (CLK_FREQ / BAUD_RATE);
  localparam int CM0 = (RX_DELAY > READ_LATENCY) ? RX_DELAY : READ_LATENCY;
  localparam int CMX = (CM0 > POLL_GAP) ? CM0 : POLL_GAP;
  localparam int CW = $clog2(CMX + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAT_END = CW'(READ_LATENCY - 1);
  localparam logic [CW-1:0] GAP_END = CW'(POLL_GAP - 1);
  localparam logic [CW-1:0] DLY_END = CW'(RX_DELAY - 1);
  localparam logic [TW-1:0] TO_END = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, POLL_RD, POLL_WT, WRITE,
    GAP, RX_DLY, RX_RD, RX_WT
  } state_t;

  state_t        state, state_n, pick;
  logic [CW-1:0] cnt;
  logic [TW-1:0] to_cnt;
  logic [7:0]    hold;
  logic          hold_full;
  logic          take, to_hit;
  logic          drop_n, rx_set;
  logic          rd_n, wr_n;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          drop;
  logic          read, write;
  logic [3:0]    address, byteenable;
  logic [31:0]   writedata;
  logic          unused_bits;

  assign take   = bus.tx_valid_i && !hold_full;
  assign to_hit = hold_full && (to_cnt == TO_END);
  assign rd_n   = (state_n == POLL_RD) || (state_n == RX_RD);
  assign wr_n   = (state_n == WRITE);

  always_comb begin
    pick    = IDLE;
    state_n = state;
    drop_n  = 1'b0;
    rx_set  = 1'b0;
    if (bus.irq_i && !rx_valid) pick = RX_DLY;
    else if (hold_full)         pick = POLL_RD;
    unique case (state)
      IDLE: begin
        if (pick == RX_DLY) state_n = RX_DLY;
        else if (to_hit)    drop_n  = 1'b1;
        else                state_n = pick;
      end
      POLL_RD: state_n = POLL_WT;
      POLL_WT: begin
        if (cnt == LAT_END)
          state_n = bus.avm_readdata_i[0] ? WRITE : GAP;
      end
      WRITE: state_n = GAP;
      GAP: begin
        // last gap cycle makes the idle decision itself,
        // so back-to-back polls sit GAP+LAT+1 apart
        if (to_hit) begin
          drop_n  = 1'b1;
          state_n = IDLE;
        end else if (cnt == GAP_END) begin
          state_n = pick;
        end
      end
      RX_DLY: if (cnt == DLY_END) state_n = RX_RD;
      RX_RD:  state_n = RX_WT;
      RX_WT: begin
        if (cnt == LAT_END) begin
          rx_set  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state      <= IDLE;
      cnt        <= '0;
      to_cnt     <= '0;
      hold       <= '0;
      hold_full  <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      drop       <= 1'b0;
      read       <= 1'b0;
      write      <= 1'b0;
      address    <= '0;
      byteenable <= '0;
      writedata  <= '0;
    end else begin
      state <= state_n;
      if (state_n != state)  cnt <= '0;
      else if (cnt != '1)    cnt <= cnt + CW'(1);

      if (wr_n || drop_n) begin
        hold_full <= 1'b0;
        to_cnt    <= '0;
      end else if (take) begin
        hold_full <= 1'b1;
        hold      <= bus.tx_data_i;
        to_cnt    <= '0;
      end else if (hold_full && to_cnt != TO_END) begin
        to_cnt <= to_cnt + TW'(1);
      end

      if (rx_set) begin
        rx_valid <= 1'b1;
        rx_data  <= bus.avm_readdata_i[7:0];
      end else if (rx_valid && bus.rx_ready_i) begin
        rx_valid <= 1'b0;
      end

      drop       <= drop_n;
      read       <= rd_n;
      write      <= wr_n;
      byteenable <= {4{rd_n || wr_n}};
      writedata  <= wr_n ? {24'd0, hold} : 32'd0;
      unique case (1'b1)
        state_n == POLL_RD: address <= 4'd1;
        state_n == RX_RD:   address <= 4'd2;
        default:            address <= 4'd0;
      endcase
    end
  end

  assign unused_bits          = ^bus.avm_readdata_i[31:8];
  assign bus.tx_ready_o       = !hold_full;
  assign bus.tx_drop_o        = drop;
  assign bus.rx_data_o        = rx_data;
  assign bus.rx_valid_o       = rx_valid;
  assign bus.avm_address_o    = address;
  assign bus.avm_byteenable_o = byteenable;
  assign bus.avm_read_o       = read;
  assign bus.avm_write_o      = write;
  assign bus.avm_writedata_o  = writedata;
endmodule

// File: tb/tb_uart_av_master.sv
// Bench for uart_av_master: models uart_core's register port and IRQ,
// logs every bus access and compares against cycle arithmetic.
module tb_uart_av_master;
  localparam int CF = 400;
  localparam int BR = 100;
  localparam int L  = 2;
  localparam int G  = 4;
  localparam int T  = 100;
  localparam int D  = 10 * (CF / BR);
  localparam int P  = G + L + 1;
  localparam logic [31:0] GARB = 32'hA5A5_A5A4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  uart_av_master_if bus ();

  uart_av_master #(
    .CLK_FREQ(CF), .BAUD_RATE(BR), .READ_LATENCY(L),
    .POLL_GAP(G), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk_i(clk), .reset_n_i(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    bit          wr;
    logic [3:0]  addr;
    logic [31:0] data;
  } txn_t;

  typedef struct {
    logic [7:0]  data;
    int          busy;
    logic [31:0] exp_wdata;
    int          exp_reads;
  } vec_t;

  txn_t log_q[$];
  int   drop_q[$];
  int   cyc = 0;
  int   polls = 0;
  int   served = 0;
  int   raised = 0;
  int   ready_at = 0;
  int   due = -1;
  int   viol = 0;
  bit   prev_rd = 1'b0;
  logic [31:0] resp = '0;
  logic [7:0]  rx_byte = '0;
  int   checks = 0;
  int   failures = 0;

  // core IRQ: pending while raises outnumber addr-2 reads
  assign bus.irq_i = (raised != served);

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.avm_read_o && bus.avm_write_o) viol++;
    if ((bus.avm_read_o || bus.avm_write_o) !=
        (bus.avm_byteenable_o == 4'hF)) viol++;
    if (!bus.avm_read_o && !bus.avm_write_o &&
        bus.avm_address_o != 4'd0) viol++;
    if (bus.avm_read_o && prev_rd) viol++;
    prev_rd = bus.avm_read_o;
    if (bus.avm_read_o) begin
      log_q.push_back('{cyc, 1'b0, bus.avm_address_o, 32'd0});
      due = cyc + L;
      if (bus.avm_address_o == 4'd2) begin
        resp = {24'd0, rx_byte};
        served++;
      end else begin
        resp = {31'd0, polls >= ready_at};
        polls++;
      end
    end
    if (bus.avm_write_o)
      log_q.push_back('{cyc, 1'b1, bus.avm_address_o,
                        bus.avm_writedata_o});
    if (bus.tx_drop_o) drop_q.push_back(cyc);
  end

  // read data valid only on the cycle READ_LATENCY after the strobe
  always @(posedge clk) begin
    #1;
    bus.avm_readdata_i = (cyc == due) ? resp : GARB;
  end

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int find_txn(int from, bit wr, logic [3:0] addr,
                                  int k);
    int n = k;
    for (int i = from; i < log_q.size(); i++)
      if (log_q[i].wr == wr && log_q[i].addr == addr) begin
        if (n == 0) return i;
        n--;
      end
    return -1;
  endfunction

  function automatic int count_txn(int from, bit wr, logic [3:0] addr);
    int n = 0;
    for (int i = from; i < log_q.size(); i++)
      if (log_q[i].wr == wr && log_q[i].addr == addr) n++;
    return n;
  endfunction

  function automatic int cyc_of(int idx);
    return (idx < 0) ? -1 : log_q[idx].cyc;
  endfunction

  function automatic logic [31:0] data_of(int idx);
    return (idx < 0) ? 32'hFFFF_FFFF : log_q[idx].data;
  endfunction

  task automatic send(input logic [7:0] d, output int c);
    int n = 0;
    @(negedge clk);
    while (!bus.tx_ready_o && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("tx_ready_before_send", bus.tx_ready_o, 1);
    bus.tx_data_i  = d;
    bus.tx_valid_i = 1'b1;
    c = cyc + 1;
    @(negedge clk);
    bus.tx_valid_i = 1'b0;
  endtask

  task automatic wait_rx(output int vc);
    int n = 0;
    while (!bus.rx_valid_o && n < D + L + 20) begin
      @(negedge clk);
      n++;
    end
    vc = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[$];
    int c, r, k, vc, base, dbase, idx, o, er;
    logic [7:0] d, b2;

    bus.tx_data_i  = '0;
    bus.tx_valid_i = 1'b0;
    bus.rx_ready_i = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_outputs",
          {bus.avm_read_o, bus.avm_write_o, bus.avm_address_o,
           bus.avm_byteenable_o, bus.tx_drop_o, bus.rx_valid_o,
           bus.tx_ready_o}, 13'h1);
    check("reset_wdata", bus.avm_writedata_o, 0);
    check("reset_rx_data", bus.rx_data_o, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // TX vectors: fixed corners first, then random bytes/busy counts
    vecs.push_back('{8'h48, 0, 32'h48, 1});
    vecs.push_back('{8'hC3, 3, 32'hC3, 4});
    vecs.push_back('{8'h00, 1, 32'h00, 2});
    vecs.push_back('{8'hFF, 2, 32'hFF, 3});
    for (int i = 0; i < 6; i++) begin
      int bb;
      d  = 8'($urandom);
      bb = int'($urandom_range(0, 4));
      vecs.push_back('{d, bb, {24'd0, d}, bb + 1});
    end

    foreach (vecs[i]) begin
      int bad;
      base     = log_q.size();
      ready_at = polls + vecs[i].busy;
      send(vecs[i].data, c);
      repeat (vecs[i].busy * P + L + G + 10) @(negedge clk);
      check($sformatf("v%0d_reads", i), count_txn(base, 0, 4'd1),
            vecs[i].exp_reads);
      bad = 0;
      for (int j = 0; j < vecs[i].exp_reads; j++)
        if (cyc_of(find_txn(base, 0, 4'd1, j)) != c + 1 + j * P) bad++;
      check($sformatf("v%0d_read_spacing", i), bad, 0);
      check($sformatf("v%0d_writes", i), count_txn(base, 1, 4'd0), 1);
      idx = find_txn(base, 1, 4'd0, 0);
      check($sformatf("v%0d_write_cyc", i), cyc_of(idx),
            c + 1 + vecs[i].busy * P + L + 1);
      check($sformatf("v%0d_wdata", i), data_of(idx),
            vecs[i].exp_wdata);
      check($sformatf("v%0d_tx_ready", i), bus.tx_ready_o, 1);
    end

    // timeout: status never ready
    base     = log_q.size();
    dbase    = drop_q.size();
    ready_at = 32'h4000_0000;
    send(8'h77, c);
    o = T - 1;
    while (o != 0 && ((o - 1) % P) <= L) o++;
    er = (o - 1) / P + 1;
    k = 0;
    while (drop_q.size() == dbase && k < T + 3 * P) begin
      @(negedge clk);
      k++;
    end
    repeat (5) @(negedge clk);
    check("to_drop_count", drop_q.size() - dbase, 1);
    check("to_drop_cyc",
          (drop_q.size() > dbase) ? drop_q[dbase] : -1, c + o + 1);
    check("to_reads", count_txn(base, 0, 4'd1), er);
    check("to_writes", count_txn(base, 1, 4'd0), 0);
    check("to_tx_ready", bus.tx_ready_o, 1);
    repeat (G + 2) @(negedge clk);

    // RX with backpressure
    base    = log_q.size();
    rx_byte = 8'h5A;
    raised++;
    r = cyc + 1;
    wait_rx(vc);
    check("rx_read_cyc", cyc_of(find_txn(base, 0, 4'd2, 0)), r + D);
    check("rx_valid_cyc", vc, r + D + L + 1);
    check("rx_data", bus.rx_data_o, 8'h5A);
    @(negedge clk);
    raised++;
    repeat (2 * D) @(negedge clk);
    check("bp_no_read", count_txn(base, 0, 4'd2), 1);
    check("bp_held", {bus.rx_valid_o, bus.rx_data_o}, {1'b1, 8'h5A});
    b2 = 8'($urandom);
    rx_byte = b2;
    bus.rx_ready_i = 1'b1;
    k = cyc + 1;
    @(negedge clk);
    bus.rx_ready_i = 1'b0;
    check("bp_consumed", bus.rx_valid_o, 0);
    wait_rx(vc);
    check("bp_read_cyc", cyc_of(find_txn(base, 0, 4'd2, 1)), k + 1 + D);
    check("bp_valid_cyc", vc, k + 1 + D + L + 1);
    check("bp_data", bus.rx_data_o, b2);
    bus.rx_ready_i = 1'b1;
    @(negedge clk);

    // simultaneous TX capture and irq: RX first
    base     = log_q.size();
    ready_at = polls;
    b2       = 8'($urandom);
    rx_byte  = b2;
    bus.tx_data_i  = 8'h3C;
    bus.tx_valid_i = 1'b1;
    raised++;
    c = cyc + 1;
    @(negedge clk);
    bus.tx_valid_i = 1'b0;
    repeat (D + 2 * L + G + 15) @(negedge clk);
    check("sim_rx_read", cyc_of(find_txn(base, 0, 4'd2, 0)), c + D);
    check("sim_poll", cyc_of(find_txn(base, 0, 4'd1, 0)), c + D + L + 2);
    idx = find_txn(base, 1, 4'd0, 0);
    check("sim_write", cyc_of(idx), c + D + 2 * L + 3);
    check("sim_wdata", data_of(idx), 32'h3C);
    check("sim_rx", {bus.rx_valid_o, bus.rx_data_o}, {1'b0, b2});
    bus.rx_ready_i = 1'b0;

    // reset while a poll read is waiting for data
    raised++;
    @(negedge clk);
    wait_rx(vc);
    check("rst_pre_rx_valid", bus.rx_valid_o, 1);
    ready_at = 32'h4000_0000;
    base     = log_q.size();
    dbase    = drop_q.size();
    send(8'h99, c);
    @(negedge clk);
    @(negedge clk);
    check("rst_mid_wt", cyc_of(find_txn(base, 0, 4'd1, 0)), c + 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_outputs",
          {bus.avm_read_o, bus.avm_write_o, bus.avm_address_o,
           bus.avm_byteenable_o, bus.tx_drop_o, bus.rx_valid_o,
           bus.tx_ready_o}, 13'h1);
    rst_n = 1'b1;
    base = log_q.size();
    repeat (3 * P + 5) @(negedge clk);
    check("rst_no_access", log_q.size() - base, 0);
    check("rst_no_drop", drop_q.size() - dbase, 0);
    check("rst_rx_empty", bus.rx_valid_o, 0);

    check("bus_invariants", viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
